// File: rtl/uart_rx_oversampled_pkg.sv
// Shared definitions for the UART receive engine: state encoding, default
// frame geometry and the build-time feature switches.
// Optional feature macro: UART_RX_PARITY_EN (even parity bit between data and stop).

`ifndef CLOCK_RATE
`define CLOCK_RATE 100000000
`endif
`ifndef BAUD_RATE
`define BAUD_RATE 115200
`endif
// Uncomment to add an even-parity bit to every received frame.
// `define UART_RX_PARITY_EN

package uart_rx_oversampled_pkg;

  localparam int unsigned DEFAULT_DATA_BITS  = 8;
  localparam int unsigned DEFAULT_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rxState_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; both flops
// reset to RESET_VALUE so an idle line never looks like an edge.

module uart_sync2 #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the async input through two flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_oversampled.sv
// 16x-oversampled UART receiver. Recovers DATA_BITS-N-1 frames (LSB first)
// from rx, emitting one-clk data_valid / framing_error / parity_error strobes.
// Optional feature macro: UART_RX_PARITY_EN (adds an even-parity bit).

module uart_rx_oversampled
  import uart_rx_oversampled_pkg::*;
#(
  parameter int unsigned DATA_BITS  = DEFAULT_DATA_BITS,
  parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 framing_error,
  output logic                 parity_error,
  output logic                 busy
);

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  rxState_t             state, stateNext;
  logic [TICK_W-1:0]    tickCnt, tickCntNext;
  logic [BIT_W-1:0]     bitCnt, bitCntNext;
  logic [DATA_BITS-1:0] shiftReg, shiftNext;
  logic [DATA_BITS-1:0] dataNext;
  logic                 validNext, framingNext;
  logic                 rxS;

  uart_sync2 #(.RESET_VALUE(1'b1)) rxSync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rxS)
  );

`ifdef UART_RX_PARITY_EN
  logic parityBad, parityBadNext, parityNext;
`else
  assign parity_error = 1'b0;
`endif

  // State, counters, shift register and output strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      tickCnt       <= '0;
      bitCnt        <= '0;
      shiftReg      <= '0;
      data_out      <= '0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parityBad     <= 1'b0;
      parity_error  <= 1'b0;
`endif
    end else begin
      state         <= stateNext;
      tickCnt       <= tickCntNext;
      bitCnt        <= bitCntNext;
      shiftReg      <= shiftNext;
      data_out      <= dataNext;
      data_valid    <= validNext;
      framing_error <= framingNext;
`ifdef UART_RX_PARITY_EN
      parityBad     <= parityBadNext;
      parity_error  <= parityNext;
`endif
    end
  end

  // Next-state and strobe decode; everything advances only on rx_tick
  always_comb begin
    stateNext   = state;
    tickCntNext = tickCnt;
    bitCntNext  = bitCnt;
    shiftNext   = shiftReg;
    dataNext    = data_out;
    validNext   = 1'b0;
    framingNext = 1'b0;
`ifdef UART_RX_PARITY_EN
    parityBadNext = parityBad;
    parityNext    = 1'b0;
`endif
    if (rx_tick) begin
      case (state)
        IDLE: begin
          if (!rxS) begin
            stateNext   = START;
            tickCntNext = '0;
          end
        end
        START: begin
          if (tickCnt == HALF_LAST) begin
            tickCntNext = '0;
            bitCntNext  = '0;
            stateNext   = rxS ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            parityBadNext = 1'b0;
`endif
          end else begin
            tickCntNext = tickCnt + 1'b1;
          end
        end
        DATA: begin
          if (tickCnt == FULL_LAST) begin
            shiftNext   = {rxS, shiftReg[DATA_BITS-1:1]};
            tickCntNext = '0;
            bitCntNext  = bitCnt + 1'b1;
            if (bitCnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              stateNext = PARITY;
`else
              stateNext = STOP;
`endif
            end
          end else begin
            tickCntNext = tickCnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tickCnt == FULL_LAST) begin
            parityBadNext = (^shiftReg) ^ rxS;
            tickCntNext   = '0;
            stateNext     = STOP;
          end else begin
            tickCntNext = tickCnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (tickCnt == FULL_LAST) begin
            tickCntNext = '0;
            if (rxS) begin
              dataNext  = shiftReg;
              validNext = 1'b1;
              stateNext = IDLE;
`ifdef UART_RX_PARITY_EN
              parityNext = parityBad;
`endif
            end else begin
              framingNext = 1'b1;
              stateNext   = BREAK;
            end
          end else begin
            tickCntNext = tickCnt + 1'b1;
          end
        end
        BREAK: begin
          if (rxS) stateNext = IDLE;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: rx_tick every 4 clk (64 clk/bit),
// frames driven on the negedge, strobes counted by a negedge monitor.

module tb_uart_rx_oversampled;

  localparam int unsigned BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       data_valid, framing_error, parity_error, busy;

  int total = 0;
  int bad = 0;
  int validCnt = 0;
  int ferrCnt = 0;
  int perrCnt = 0;
  int perrWithValid = 0;
  logic [7:0] rxq[$];

  uart_rx_oversampled #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_tick       (rx_tick),
    .rx            (rx),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .framing_error (framing_error),
    .parity_error  (parity_error),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Tick generator: one clk-wide strobe every 4 clk
  initial begin
    int unsigned n = 0;
    forever begin
      @(negedge clk);
      n++;
      rx_tick = (n % 4 == 0);
    end
  end

  // Strobe monitor
  always @(negedge clk) begin
    if (data_valid) begin
      validCnt++;
      rxq.push_back(data_out);
      if (parity_error) perrWithValid++;
    end
    if (framing_error) ferrCnt++;
    if (parity_error) perrCnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sendBit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic sendFrameRaw(input logic [7:0] d, input logic parBit, input logic stopBit);
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(d[i]);
`ifdef UART_RX_PARITY_EN
    sendBit(parBit);
`else
    if (parBit !== parBit) sendBit(1'b1);
`endif
    sendBit(stopBit);
  endtask

  task automatic sendFrame(input logic [7:0] d);
    sendFrameRaw(d, ^d, 1'b1);
  endtask

  initial begin
    logic [7:0] got;
    repeat (3) @(negedge clk);
    check("reset_data_out", {24'h0, data_out}, 32'h0);
    check("reset_valid", {31'h0, data_valid}, 32'h0);
    check("reset_ferr", {31'h0, framing_error}, 32'h0);
    check("reset_perr", {31'h0, parity_error}, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    reset = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);

    // Single frame 0xA5
    sendFrame(8'hA5);
    sendBit(1'b1);
    check("a5_valid_cnt", validCnt, 1);
    got = (rxq.size() > 0) ? rxq.pop_front() : 8'hxx;
    check("a5_value", {24'h0, got}, 32'hA5);
    check("a5_data_out", {24'h0, data_out}, 32'hA5);
    check("a5_ferr_cnt", ferrCnt, 0);
    check("a5_busy", {31'h0, busy}, 32'h0);

    // Back-to-back 0x3C, 0xC3 with no idle bits
    sendFrame(8'h3C);
    sendFrame(8'hC3);
    sendBit(1'b1);
    check("b2b_valid_cnt", validCnt, 3);
    got = (rxq.size() > 0) ? rxq.pop_front() : 8'hxx;
    check("b2b_first", {24'h0, got}, 32'h3C);
    got = (rxq.size() > 0) ? rxq.pop_front() : 8'hxx;
    check("b2b_second", {24'h0, got}, 32'hC3);

    // 3-tick low glitch: false start
    rx = 1'b0;
    repeat (12) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    check("glitch_valid_cnt", validCnt, 3);
    check("glitch_ferr_cnt", ferrCnt, 0);
    check("glitch_busy", {31'h0, busy}, 32'h0);

    // Framing error with line held low, then recovery
    sendFrameRaw(8'h55, ^8'h55, 1'b0);
    rx = 1'b0;
    repeat (40 * 4) @(negedge clk);
    check("brk_ferr_cnt", ferrCnt, 1);
    check("brk_valid_cnt", validCnt, 3);
    check("brk_data_out", {24'h0, data_out}, 32'hC3);
    check("brk_busy_held", {31'h0, busy}, 32'h1);
    sendBit(1'b1);
    check("brk_busy_release", {31'h0, busy}, 32'h0);
    sendFrame(8'h12);
    sendBit(1'b1);
    check("post_brk_valid_cnt", validCnt, 4);
    got = (rxq.size() > 0) ? rxq.pop_front() : 8'hxx;
    check("post_brk_value", {24'h0, got}, 32'h12);
    check("post_brk_ferr_cnt", ferrCnt, 1);

    // Async reset during bit 4 of 0xFF
    sendBit(1'b0);
    for (int i = 0; i < 4; i++) sendBit(1'b1);
    repeat (BIT_CLKS / 2) @(negedge clk);
    check("pre_rst_busy", {31'h0, busy}, 32'h1);
    #2 reset = 1'b1;
    #1;
    check("rst_data_out", {24'h0, data_out}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_valid", {31'h0, data_valid}, 32'h0);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (2 * BIT_CLKS) @(negedge clk);
    check("rst_no_stale_valid", validCnt, 4);
    sendFrame(8'h81);
    sendBit(1'b1);
    check("post_rst_valid_cnt", validCnt, 5);
    got = (rxq.size() > 0) ? rxq.pop_front() : 8'hxx;
    check("post_rst_value", {24'h0, got}, 32'h81);
    check("post_rst_ferr_cnt", ferrCnt, 1);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: even parity bit is 1, so 0 is a mismatch
    sendFrameRaw(8'h07, 1'b0, 1'b1);
    sendBit(1'b1);
    check("par_bad_valid_cnt", validCnt, 6);
    check("par_bad_perr_with_valid", perrWithValid, 1);
    check("par_bad_perr_cnt", perrCnt, 1);
    got = (rxq.size() > 0) ? rxq.pop_front() : 8'hxx;
    check("par_bad_value", {24'h0, got}, 32'h07);
    sendFrameRaw(8'h07, 1'b1, 1'b1);
    sendBit(1'b1);
    check("par_good_valid_cnt", validCnt, 7);
    check("par_good_perr_cnt", perrCnt, 1);
`else
    check("no_parity_perr_cnt", perrCnt, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_rx_oversampled.md
Name: uart_rx_oversampled

Overview:
- UART receive engine for the serial interface. Runs entirely in the clk domain.
- Recovers 8N1 frames from the asynchronous serial input using a 16x-oversampling enable tick from the baud generator.
- Presents each received byte with a one-cycle valid strobe plus error flags.
- Counterpart to the UART transmitter; the parent instantiates it beside the baud generator.

Parameters:
- DATA_BITS, 8, number of data bits per frame, LSB first; legal range 5..8.
- OVERSAMPLE, 16, rx_tick strobes per bit period; must be even and at least 8.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- rx_tick  input  1  one-clk-wide enable strobe at OVERSAMPLE x baud rate
- rx  input  1  asynchronous serial line; idle high
- data_out  output  DATA_BITS  last received data word
- data_valid  output  1  one-clk pulse when data_out is updated by a good frame
- framing_error  output  1  one-clk pulse when the stop bit is sampled low
- parity_error  output  1  one-clk pulse on parity mismatch; tied 0 when PARITY_EN is undefined
- busy  output  1  high whenever the state is not IDLE

Behaviour:
- Reset values:
  - data_out = 0; data_valid, framing_error, parity_error, busy = 0.
  - State = IDLE; tick counter = 0; bit counter = 0.
  - Synchronizer flops = 1.
- Input synchronizer: rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s.
- All state and counter updates occur only on clk edges where rx_tick = 1, except the output strobes, which are cleared on the following clk.
- IDLE:
  - On a tick with rx_s = 0: go to START, tick counter = 0.
- START (mid-bit check of the start bit):
  - Count ticks.
  - When the counter reaches OVERSAMPLE/2 - 1:
    - If rx_s = 0: go to DATA, tick counter = 0, bit counter = 0.
    - Otherwise (glitch/false start): go to IDLE with no outputs asserted.
- DATA:
  - Count ticks.
  - At counter = OVERSAMPLE - 1: shift rx_s into the shift register MSB side (LSB-first reception), reset the counter, increment the bit counter.
  - After bit DATA_BITS-1: go to PARITY if PARITY_EN is defined, else go to STOP.
- STOP:
  - At counter = OVERSAMPLE - 1, sample rx_s.
  - If rx_s = 1:
    - data_out <= shift register.
    - data_valid = 1 for exactly one clk.
    - parity_error pulses in the same cycle if a parity mismatch was latched.
    - Go to IDLE.
  - If rx_s = 0:
    - framing_error = 1 for one clk; data_out is not updated; data_valid stays 0.
    - Go to BREAK.
- BREAK:
  - Stay until a tick with rx_s = 1, then go to IDLE.
  - Prevents a held-low line from retriggering frames.
- Latency: data_valid asserts one clk after the rx_tick that samples the stop bit. Total frame time is about 9.5 bit periods (8N1) from the falling edge to data_valid.
- A tick arriving in the same clk that data_valid is high is processed normally.
- Back-to-back frames: a start bit directly after the stop sample is accepted. IDLE detects it on the next tick.
- Async reset mid-frame: the frame is discarded. Outputs return to reset values immediately; no strobe is emitted.
- Widths:
  - Tick counter is $clog2(OVERSAMPLE) bits and wraps only via explicit reset.
  - Bit counter is $clog2(DATA_BITS+1) bits.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA; it samples the parity bit at mid-bit (counter = OVERSAMPLE - 1), then goes to STOP.
  - Even parity: the XOR of the data bits and the parity bit must be 0.
  - A mismatch is latched; parity_error pulses with the stop-bit result. data_valid still pulses if the stop bit is good.
  - A framing error suppresses parity_error.
- Undefined: no PARITY state; parity_error is constant 0; frame format is 8N1.

Decomposition:
- Shared package/include holds:
  - State encoding constants: IDLE, START, DATA, PARITY, STOP, BREAK.
  - Default DATA_BITS and OVERSAMPLE values.
  - The UART_RX_PARITY_EN definition point alongside the existing CLOCK_RATE/BAUD_RATE defines.
- One natural sub-module: uart_sync2, the 2-flop synchronizer with a reset value parameter (reset to 1 here). It is reusable for the transmitter's CTS-style inputs.

Test Plan:
- Send 0xA5 as 8N1 with rx_tick every 4 clk -> exactly one data_valid pulse; data_out = 0xA5; framing_error = 0; busy low afterwards.
- Send 0x3C then 0xC3 back-to-back with no idle bits -> two data_valid pulses, values 0x3C then 0xC3.
- rx low pulse of 3 ticks, then high -> returns to IDLE from START; no data_valid, no framing_error.
- Frame 0x55 with the stop bit driven low and the line held low for 40 ticks -> one framing_error pulse, data_out unchanged, state held in BREAK until rx high; then 0x12 is received correctly.
- Assert reset during bit 4 of 0xFF -> outputs go to 0 immediately; the subsequent frame 0x81 is received correctly with no stale strobe.
- With UART_RX_PARITY_EN, send 0x07 with parity bit 0 -> data_valid = 1 and parity_error = 1 in the same cycle. Parity bit 1 -> data_valid only.
